// File: rtl/mmio_uart_responder_if.sv
// CPU memory-bus signals seen by the IO responder, plus its registered read-back path.
// The master side is the CPU, the slave side is mmio_uart_responder.
interface mmio_uart_responder_if;
   logic [31:0] mem_addr;
   logic        mem_rstrb;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        io_sel_q;
   logic [31:0] io_rdata;

   modport master (
      output mem_addr, mem_rstrb, mem_wdata, mem_wmask,
      input  io_sel_q, io_rdata
   );

   modport slave (
      input  mem_addr, mem_rstrb, mem_wdata, mem_wmask,
      output io_sel_q, io_rdata
   );
endinterface

// File: rtl/mmio_uart_responder.sv
// IO-page responder: LED register, FIFO-buffered 8N1 UART transmitter, UART status
// and a free-running cycle counter, all behind one word-indexed register page.
module mmio_uart_responder #(
   parameter int IO_BIT       = 22,
   parameter int CLKS_PER_BIT = 104,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                    CLK,
   input  logic                    RESET,
   mmio_uart_responder_if.slave    bus,
   output logic [3:0]              LEDS,
   output logic                    TXD
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);

   localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);
   localparam logic [BAUD_W-1:0] BAUD_LAST_C = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]        REG_LEDS    = 4'd0;
   localparam logic [3:0]        REG_DATA    = 4'd1;
   localparam logic [3:0]        REG_STATUS  = 4'd2;
   localparam logic [3:0]        REG_CYCLES  = 4'd3;

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_t;

   logic             sel_s, rd_s, wr_s, data_wr_s, full_s, busy_s, push_s, pop_s;
   logic             baud_done_s, unused_ok_s;
   logic [3:0]       reg_idx_s;
   logic [31:0]      status_s, rd_val_s;

   logic [31:0]      io_rdata_r, cycles_r;
   logic             io_sel_r, overflow_r, txd_r;
   logic [3:0]       leds_r;
   logic [7:0]       fifo_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
   logic [CNT_W-1:0] count_r;

   tx_state_t        state_r, state_nxt_s;
   logic [BAUD_W-1:0] baud_r, baud_nxt_s;
   logic [2:0]       bit_r, bit_nxt_s;
   logic [7:0]       shift_r, shift_nxt_s;
   logic             txd_nxt_s;

   assign unused_ok_s = &{1'b0, bus.mem_addr, bus.mem_wdata};

   // Address decode, FIFO push qualification and read-data selection.
   always_comb begin
      sel_s     = bus.mem_addr[IO_BIT];
      reg_idx_s = bus.mem_addr[5:2];
      rd_s      = sel_s & bus.mem_rstrb;
      wr_s      = sel_s & (bus.mem_wmask != 4'b0000);
      data_wr_s = wr_s & bus.mem_wmask[0] & (reg_idx_s == REG_DATA);
      full_s    = (count_r == DEPTH_C);
      push_s    = data_wr_s & ~full_s;
      busy_s    = (state_r != ST_IDLE) | (count_r != '0);
      status_s  = {16'h0000, 8'(count_r), 5'b00000, overflow_r, full_s, busy_s};
      case (reg_idx_s)
         REG_LEDS:   rd_val_s = {28'h0000000, leds_r};
         REG_DATA:   rd_val_s = 32'h0000_0000;
         REG_STATUS: rd_val_s = status_s;
         REG_CYCLES: rd_val_s = cycles_r;
         default:    rd_val_s = 32'h0000_0000;
      endcase
   end

   // Bus-visible registers: read data, rdata mux select, LEDs, sticky overflow, cycle counter.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         io_rdata_r <= 32'h0000_0000;
         io_sel_r   <= 1'b0;
         leds_r     <= 4'h0;
         overflow_r <= 1'b0;
         cycles_r   <= 32'h0000_0000;
      end else begin
         io_sel_r <= rd_s;
         cycles_r <= cycles_r + 32'd1;
         if (rd_s) begin
            io_rdata_r <= rd_val_s;
         end
         if (wr_s && bus.mem_wmask[0] && (reg_idx_s == REG_LEDS)) begin
            leds_r <= bus.mem_wdata[3:0];
         end
         // A dropped write on the same edge as a STATUS read leaves overflow set.
         if (data_wr_s && full_s) begin
            overflow_r <= 1'b1;
         end else if (rd_s && (reg_idx_s == REG_STATUS)) begin
            overflow_r <= 1'b0;
         end
      end
   end

   // FIFO storage; contents are don't-care while the count says empty, so no reset.
   always_ff @(posedge CLK) begin
      if (push_s) begin
         fifo_mem_r[wr_ptr_r] <= bus.mem_wdata[7:0];
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Transmitter next-state: baud counter restarts on every state or bit change.
   always_comb begin
      state_nxt_s = state_r;
      baud_nxt_s  = baud_r;
      bit_nxt_s   = bit_r;
      shift_nxt_s = shift_r;
      txd_nxt_s   = txd_r;
      pop_s       = 1'b0;
      baud_done_s = (baud_r == BAUD_LAST_C);
      case (state_r)
         ST_IDLE: begin
            if (count_r != '0) begin
               pop_s       = 1'b1;
               shift_nxt_s = fifo_mem_r[rd_ptr_r];
               txd_nxt_s   = 1'b0;
               baud_nxt_s  = '0;
               state_nxt_s = ST_START;
            end else begin
               txd_nxt_s = 1'b1;
            end
         end
         ST_START: begin
            if (baud_done_s) begin
               baud_nxt_s  = '0;
               bit_nxt_s   = 3'd0;
               txd_nxt_s   = shift_r[0];
               state_nxt_s = ST_DATA;
            end else begin
               baud_nxt_s = baud_r + BAUD_W'(1);
            end
         end
         ST_DATA: begin
            if (baud_done_s) begin
               baud_nxt_s = '0;
               if (bit_r == 3'd7) begin
                  txd_nxt_s   = 1'b1;
                  state_nxt_s = ST_STOP;
               end else begin
                  bit_nxt_s   = bit_r + 3'd1;
                  shift_nxt_s = {1'b0, shift_r[7:1]};
                  txd_nxt_s   = shift_r[1];
               end
            end else begin
               baud_nxt_s = baud_r + BAUD_W'(1);
            end
         end
         ST_STOP: begin
            if (baud_done_s) begin
               baud_nxt_s  = '0;
               txd_nxt_s   = 1'b1;
               state_nxt_s = ST_IDLE;
            end else begin
               baud_nxt_s = baud_r + BAUD_W'(1);
            end
         end
         default: begin
            baud_nxt_s  = '0;
            txd_nxt_s   = 1'b1;
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Transmitter state register; reset abandons any frame in flight.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_r <= ST_IDLE;
         baud_r  <= '0;
         bit_r   <= 3'd0;
         shift_r <= 8'h00;
         txd_r   <= 1'b1;
      end else begin
         state_r <= state_nxt_s;
         baud_r  <= baud_nxt_s;
         bit_r   <= bit_nxt_s;
         shift_r <= shift_nxt_s;
         txd_r   <= txd_nxt_s;
      end
   end

   assign bus.io_rdata = io_rdata_r;
   assign bus.io_sel_q = io_sel_r;
   assign LEDS         = leds_r;
   assign TXD          = txd_r;

endmodule
